// File: rtl/stack_op_sequencer.sv
// Calculator command sequencer: fetches operands from the stack, runs one or
// two passes through the shared ALU, then writes the result back with a single
// stack command. Divide-by-zero and stack overflow latch a sticky error.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a command; operands are captured on accept
// ISSUE | issue a stack-only command, or launch the first ALU pass
// WAIT1 | first ALU pass running; CUBE chains a second pass from here
// WAIT2 | second ALU pass running (CUBE only)
// WRITE | write the ALU result back (POP_WRITE or WRITE_TOP)
// ERROR | sticky fault; leaves only through reset, stack untouched
module stack_op_sequencer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [3:0]       cmd_op,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] stk_top,
  input  logic [WIDTH-1:0] stk_next,
  input  logic [CNT_W-1:0] stk_count,
  output logic [2:0]       stk_cmd,
  output logic [WIDTH-1:0] stk_wdata,
  output logic             alu_start,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic             error
);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_PUSH  = 4'd1;
  localparam logic [3:0] OP_POP   = 4'd2;
  localparam logic [3:0] OP_SWAP  = 4'd3;
  localparam logic [3:0] OP_ADD   = 4'd4;
  localparam logic [3:0] OP_SUB   = 4'd5;
  localparam logic [3:0] OP_MUL   = 4'd6;
  localparam logic [3:0] OP_DIV   = 4'd7;
  localparam logic [3:0] OP_NEG   = 4'd8;
  localparam logic [3:0] OP_INC   = 4'd9;
  localparam logic [3:0] OP_DEC   = 4'd10;
  localparam logic [3:0] OP_SQR   = 4'd11;
  localparam logic [3:0] OP_CUBE  = 4'd12;
  localparam logic [3:0] OP_CLEAR = 4'd13;

  localparam logic [2:0] STK_NONE      = 3'd0;
  localparam logic [2:0] STK_PUSH0     = 3'd1;
  localparam logic [2:0] STK_POP       = 3'd2;
  localparam logic [2:0] STK_SWAP      = 3'd3;
  localparam logic [2:0] STK_WRITE_TOP = 3'd4;
  localparam logic [2:0] STK_POP_WRITE = 3'd5;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_MUL = 2'd2;
  localparam logic [1:0] ALU_DIV = 2'd3;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_W  = '0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT1 = 3'd2,
    WAIT2 = 3'd3,
    WRITE = 3'd4,
    ERROR = 3'd5
  } state_t;

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] top_q;
  logic [WIDTH-1:0] next_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] result_q;

  logic [WIDTH-1:0] issue_a;
  logic [WIDTH-1:0] issue_b;
  logic [1:0]       issue_op;
  logic             is_binary;
  logic             cmd_known;

  // Codes 14/15 fall outside the command set and are dropped like NOP.
  assign cmd_known = (cmd_op != OP_NOP) && (cmd_op <= OP_CLEAR);

  // Binary ops consume two stack elements and collapse them with POP_WRITE.
  assign is_binary = (op_q >= OP_ADD) && (op_q <= OP_DIV);

  assign busy = ~cmd_ready;

  // First-pass ALU operand and opcode mapping for the latched command.
  always_comb begin
    issue_a  = top_q;
    issue_b  = top_q;
    issue_op = ALU_ADD;
    case (op_q)
      OP_ADD: begin
        issue_a  = next_q;
        issue_b  = top_q;
        issue_op = ALU_ADD;
      end
      OP_SUB: begin
        issue_a  = next_q;
        issue_b  = top_q;
        issue_op = ALU_SUB;
      end
      OP_MUL: begin
        issue_a  = next_q;
        issue_b  = top_q;
        issue_op = ALU_MUL;
      end
      OP_DIV: begin
        issue_a  = next_q;
        issue_b  = top_q;
        issue_op = ALU_DIV;
      end
      OP_NEG: begin
        issue_a  = ZERO_W;
        issue_b  = top_q;
        issue_op = ALU_SUB;
      end
      OP_INC: begin
        issue_a  = top_q;
        issue_b  = ONE_W;
        issue_op = ALU_ADD;
      end
      OP_DEC: begin
        issue_a  = top_q;
        issue_b  = ONE_W;
        issue_op = ALU_SUB;
      end
      OP_SQR, OP_CUBE: begin
        issue_a  = top_q;
        issue_b  = top_q;
        issue_op = ALU_MUL;
      end
      default: begin
        issue_a  = top_q;
        issue_b  = top_q;
        issue_op = ALU_ADD;
      end
    endcase
  end

  // Sequencer FSM; every output is registered and the pulses self-clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      error     <= 1'b0;
      stk_cmd   <= STK_NONE;
      stk_wdata <= '0;
      alu_start <= 1'b0;
      alu_op    <= ALU_ADD;
      alu_a     <= '0;
      alu_b     <= '0;
      op_q      <= OP_NOP;
      top_q     <= '0;
      next_q    <= '0;
      count_q   <= ONE_C;
      result_q  <= '0;
    end else begin
      stk_cmd   <= STK_NONE;
      alu_start <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid) begin
            op_q    <= cmd_op;
            top_q   <= stk_top;
            next_q  <= stk_next;
            count_q <= stk_count;
            if (cmd_known) begin
              state     <= ISSUE;
              cmd_ready <= 1'b0;
            end
          end
        end

        ISSUE: begin
          case (op_q)
            OP_PUSH: begin
              if (count_q < DEPTH_C) begin
                stk_cmd   <= STK_PUSH0;
                state     <= IDLE;
                cmd_ready <= 1'b1;
              end else begin
                state <= ERROR;
                error <= 1'b1;
              end
            end
            OP_POP: begin
              // Popping the last element would empty the stack; zero it instead.
              if (count_q > ONE_C) begin
                stk_cmd <= STK_POP;
              end else begin
                stk_cmd   <= STK_WRITE_TOP;
                stk_wdata <= '0;
              end
              state     <= IDLE;
              cmd_ready <= 1'b1;
            end
            OP_SWAP: begin
              if (count_q > ONE_C) begin
                stk_cmd <= STK_SWAP;
              end
              state     <= IDLE;
              cmd_ready <= 1'b1;
            end
            OP_CLEAR: begin
              stk_cmd   <= STK_WRITE_TOP;
              stk_wdata <= '0;
              state     <= IDLE;
              cmd_ready <= 1'b1;
            end
            OP_DIV: begin
              if (top_q == ZERO_W) begin
                state <= ERROR;
                error <= 1'b1;
              end else begin
                alu_start <= 1'b1;
                alu_a     <= issue_a;
                alu_b     <= issue_b;
                alu_op    <= issue_op;
                state     <= WAIT1;
              end
            end
            OP_ADD, OP_SUB, OP_MUL, OP_NEG, OP_INC, OP_DEC, OP_SQR, OP_CUBE: begin
              alu_start <= 1'b1;
              alu_a     <= issue_a;
              alu_b     <= issue_b;
              alu_op    <= issue_op;
              state     <= WAIT1;
            end
            default: begin
              state     <= IDLE;
              cmd_ready <= 1'b1;
            end
          endcase
        end

        WAIT1: begin
          if (alu_done) begin
            if (op_q == OP_CUBE) begin
              // Square is back; multiply by the original top once more.
              alu_start <= 1'b1;
              alu_a     <= alu_result;
              alu_b     <= top_q;
              alu_op    <= ALU_MUL;
              state     <= WAIT2;
            end else begin
              result_q <= alu_result;
              state    <= WRITE;
            end
          end
        end

        WAIT2: begin
          if (alu_done) begin
            result_q <= alu_result;
            state    <= WRITE;
          end
        end

        WRITE: begin
          stk_cmd   <= is_binary ? STK_POP_WRITE : STK_WRITE_TOP;
          stk_wdata <= result_q;
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end

        ERROR: begin
          error     <= 1'b1;
          cmd_ready <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Scoreboard bench for stack_op_sequencer: directed commands push expected
// ALU launches and stack writes into queues; a monitor pops and compares.
module tb_stack_op_sequencer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int ALU_LAT = 3;

  logic             clock;
  logic             reset;
  logic             cmd_valid;
  logic [3:0]       cmd_op;
  logic             cmd_ready;
  logic [WIDTH-1:0] stk_top;
  logic [WIDTH-1:0] stk_next;
  logic [CNT_W-1:0] stk_count;
  logic [2:0]       stk_cmd;
  logic [WIDTH-1:0] stk_wdata;
  logic             alu_start;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_done;
  logic [WIDTH-1:0] alu_result;
  logic             busy;
  logic             error;

  stack_op_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .stk_top(stk_top), .stk_next(stk_next), .stk_count(stk_count),
    .stk_cmd(stk_cmd), .stk_wdata(stk_wdata),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result),
    .busy(busy), .error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]       cmd;
    logic [WIDTH-1:0] wdata;
    bit               lat;
  } stk_exp_t;

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } alu_exp_t;

  stk_exp_t stk_q[$];
  alu_exp_t alu_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_done = -100;
  bit stray = 0;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_alu(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    alu_exp_t e;
    e.op = op; e.a = a; e.b = b;
    alu_q.push_back(e);
  endtask

  task automatic exp_stk(input logic [2:0] c, input logic [WIDTH-1:0] d, input bit lat);
    stk_exp_t e;
    e.cmd = c; e.wdata = d; e.lat = lat;
    stk_q.push_back(e);
  endtask

  // ALU model: responds ALU_LAT negedges after a start; also injects stray pulses.
  initial begin
    int cnt;
    logic [1:0] op_c;
    logic [WIDTH-1:0] a_c, b_c;
    cnt = 0;
    op_c = '0; a_c = '0; b_c = '0;
    alu_done = 1'b0;
    alu_result = '0;
    forever begin
      @(negedge clock);
      if (alu_done) alu_done = 1'b0;
      if (stray) begin
        alu_done = 1'b1;
        alu_result = 32'h0000_005a;
        stray = 0;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          alu_done = 1'b1;
          case (op_c)
            2'd0: alu_result = a_c + b_c;
            2'd1: alu_result = a_c - b_c;
            2'd2: alu_result = a_c * b_c;
            default: alu_result = (b_c == 0) ? '0 : WIDTH'($signed(a_c) / $signed(b_c));
          endcase
        end
      end
      if (alu_start) begin
        op_c = alu_op; a_c = alu_a; b_c = alu_b;
        cnt = ALU_LAT;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an ALU launch or stack command.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (alu_done) last_done = cyc;
      if (alu_start) begin
        if (alu_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_alu_start: op=%0d a=%h b=%h (cycle %0d)", alu_op, alu_a, alu_b, cyc);
        end else begin
          alu_exp_t e;
          e = alu_q.pop_front();
          chk("alu_op", {30'd0, alu_op}, {30'd0, e.op});
          chk("alu_a", alu_a, e.a);
          chk("alu_b", alu_b, e.b);
        end
      end
      if (stk_cmd != 3'd0) begin
        if (stk_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_stk_cmd: cmd=%0d wdata=%h (cycle %0d)", stk_cmd, stk_wdata, cyc);
        end else begin
          stk_exp_t e;
          e = stk_q.pop_front();
          chk("stk_cmd", {29'd0, stk_cmd}, {29'd0, e.cmd});
          if (e.cmd == 3'd4 || e.cmd == 3'd5) chk("stk_wdata", stk_wdata, e.wdata);
          if (e.lat) chk("write_latency", WIDTH'(cyc - last_done), WIDTH'(1));
          chk("ready_with_write", {31'd0, cmd_ready}, 32'd1);
        end
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [WIDTH-1:0] top,
                      input logic [WIDTH-1:0] nxt, input logic [CNT_W-1:0] cnt);
    int n;
    n = 0;
    @(negedge clock);
    while (!cmd_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!cmd_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout: cmd_ready=%0d expected 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op = op;
    stk_top = top;
    stk_next = nxt;
    stk_count = cnt;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 4'd0;
  endtask

  // Waits for cmd_ready after an accept; exp_lat<0 means latency is not checked.
  task automatic wait_ready(input int exp_lat);
    int n;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!cmd_ready) begin
      checks++; failures++;
      $display("FAIL ready_timeout: cmd_ready=%0d expected 1", cmd_ready);
    end else if (exp_lat >= 0) begin
      chk("ready_latency", WIDTH'(n), WIDTH'(exp_lat));
    end
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 4'd0;
    stk_top = '0;
    stk_next = '0;
    stk_count = CNT_W'(1);
    repeat (3) @(posedge clock);
    #1;
    chk("rst_stk_wdata", stk_wdata, 32'd0);
    chk("rst_alu_op", {30'd0, alu_op}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Idle after reset
    repeat (4) begin
      @(posedge clock);
      #1;
      chk("idle_ready", {31'd0, cmd_ready}, 32'd1);
      chk("idle_error", {31'd0, error}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_stk_cmd", {29'd0, stk_cmd}, 32'd0);
      chk("idle_alu_start", {31'd0, alu_start}, 32'd0);
    end

    // ADD 900 + 123
    exp_alu(2'd0, 32'd900, 32'd123);
    exp_stk(3'd5, 32'd1023, 1);
    send(4'd4, 32'd123, 32'd900, 4'd2);
    wait_ready(-1);

    // DIV -1184 / -5 = 236, then 7105 / 6 = 1184
    exp_alu(2'd3, -32'sd1184, -32'sd5);
    exp_stk(3'd5, 32'd236, 1);
    send(4'd7, -32'sd5, -32'sd1184, 4'd3);
    wait_ready(-1);
    exp_alu(2'd3, 32'd7105, 32'd6);
    exp_stk(3'd5, 32'd1184, 1);
    send(4'd7, 32'd6, 32'd7105, 4'd2);
    wait_ready(-1);

    // CUBE 64: two passes
    exp_alu(2'd2, 32'd64, 32'd64);
    exp_alu(2'd2, 32'd4096, 32'd64);
    exp_stk(3'd4, 32'd262144, 1);
    send(4'd12, 32'd64, 32'd0, 4'd1);
    wait_ready(-1);

    // Unary and binary variants
    exp_alu(2'd1, 32'd10, 32'd3);
    exp_stk(3'd5, 32'd7, 1);
    send(4'd5, 32'd3, 32'd10, 4'd4);
    wait_ready(-1);
    exp_alu(2'd2, 32'd0, 32'd6);
    exp_stk(3'd5, 32'd0, 1);
    send(4'd6, 32'd6, 32'd0, 4'd1);
    wait_ready(-1);
    exp_alu(2'd1, 32'd0, 32'd5);
    exp_stk(3'd4, -32'sd5, 1);
    send(4'd8, 32'd5, 32'd9, 4'd2);
    wait_ready(-1);
    exp_alu(2'd0, 32'd41, 32'd1);
    exp_stk(3'd4, 32'd42, 1);
    send(4'd9, 32'd41, 32'd0, 4'd1);
    wait_ready(-1);
    exp_alu(2'd1, 32'd0, 32'd1);
    exp_stk(3'd4, 32'hffff_ffff, 1);
    send(4'd10, 32'd0, 32'd0, 4'd1);
    wait_ready(-1);
    exp_alu(2'd2, -32'sd7, -32'sd7);
    exp_stk(3'd4, 32'd49, 1);
    send(4'd11, -32'sd7, 32'd0, 4'd1);
    wait_ready(-1);

    // Stack-only ops
    exp_stk(3'd1, 32'd0, 0);
    send(4'd1, 32'd5, 32'd6, 4'd3);
    wait_ready(1);
    exp_stk(3'd2, 32'd0, 0);
    send(4'd2, 32'd5, 32'd6, 4'd3);
    wait_ready(1);
    exp_stk(3'd3, 32'd0, 0);
    send(4'd3, 32'd5, 32'd6, 4'd2);
    wait_ready(1);
    send(4'd3, 32'd5, 32'd0, 4'd1);
    wait_ready(1);
    exp_stk(3'd4, 32'd0, 0);
    send(4'd13, 32'd77, 32'd8, 4'd2);
    wait_ready(1);
    exp_stk(3'd4, 32'd0, 0);
    send(4'd2, 32'd55, 32'd0, 4'd1);
    wait_ready(1);
    send(4'd0, 32'd1, 32'd2, 4'd2);
    wait_ready(0);
    send(4'd14, 32'd1, 32'd2, 4'd2);
    wait_ready(0);

    // Stray alu_done while idle
    @(negedge clock);
    stray = 1;
    repeat (4) @(posedge clock);
    #1;
    chk("stray_ready", {31'd0, cmd_ready}, 32'd1);

    // Divide by zero
    send(4'd7, 32'd0, 32'd262144, 4'd2);
    repeat (4) begin
      @(posedge clock);
      #1;
      chk("div0_error", {31'd0, error}, 32'd1);
      chk("div0_ready", {31'd0, cmd_ready}, 32'd0);
      chk("div0_busy", {31'd0, busy}, 32'd1);
    end
    pulse_reset();
    @(posedge clock);
    #1;
    chk("div0_rst_error", {31'd0, error}, 32'd0);
    chk("div0_rst_ready", {31'd0, cmd_ready}, 32'd1);

    // PUSH at full stack
    send(4'd1, 32'd1, 32'd2, CNT_W'(DEPTH));
    repeat (3) begin
      @(posedge clock);
      #1;
      chk("ovf_error", {31'd0, error}, 32'd1);
      chk("ovf_ready", {31'd0, cmd_ready}, 32'd0);
    end
    pulse_reset();
    @(posedge clock);
    #1;
    chk("ovf_rst_error", {31'd0, error}, 32'd0);

    // Reset in WAIT1; the late alu_done must be ignored
    exp_alu(2'd0, 32'd2, 32'd3);
    send(4'd4, 32'd3, 32'd2, 4'd2);
    @(posedge clock);
    #1;
    pulse_reset();
    repeat (8) @(posedge clock);
    #1;
    chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
    chk("abort_error", {31'd0, error}, 32'd0);

    // Recovery after abort
    exp_alu(2'd0, 32'd99, 32'd1);
    exp_stk(3'd4, 32'd100, 1);
    send(4'd9, 32'd99, 32'd0, 4'd1);
    wait_ready(-1);

    repeat (10) @(posedge clock);
    #1;
    chk("stk_q_drained", WIDTH'(stk_q.size()), 32'd0);
    chk("alu_q_drained", WIDTH'(alu_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
